// File: rtl/alu_seq.sv
// alu_seq : sequenced single-issue ALU with a valid/ready request and
// result handshake.
//
// A request (in_op one-hot, in_a, in_b) is captured when in_valid and
// in_ready are both high. Non-shift operations produce their result one
// cycle later. Shifts use a serial one-bit-per-cycle datapath by default,
// so a shift by N delivers its result N+1 cycles after accept. A shift by
// zero behaves like a non-shift operation. A non-one-hot in_op is still
// accepted and answers with out_err = 1 and out_result = 0. The result is
// held in DONE until the consumer takes it.
//
// Build option:
//   ALU_SEQ_FAST_SHIFT_EN - when defined, shifts go through a barrel
//   shifter with latency 1 and the SHIFT state is never entered. The
//   results are identical in both builds.
//
// Parameters:
//   WIDTH      - operand/result width, power of two from 8 to 64
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - request present
//   in_ready   - request accepted this cycle (IDLE only, low during reset)
//   in_op      - one-hot operation: 0 add, 1 sub, 2 xor, 3 or, 4 and,
//                5 sll, 6 srl, 7 sra, 8 slt, 9 sltu
//   in_a       - operand A
//   in_b       - operand B; low log2(WIDTH) bits are the shift amount
//   out_valid  - result available
//   out_ready  - consumer takes the result this cycle
//   out_result - operation result
//   out_err    - accepted in_op was not one-hot
//   busy       - state is not IDLE
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [SW-1:0]    shamt;
    logic             op_onehot;
    logic [WIDTH-1:0] alu_result;

`ifndef ALU_SEQ_FAST_SHIFT_EN
    localparam logic [SW-1:0] CNT_ONE = SW'(1);

    logic             is_shift;
    logic [SW-1:0]    cnt;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_next;
    logic [2:0]       shift_kind;

    assign is_shift = |in_op[7:5];
`endif

    assign shamt     = in_b[SW-1:0];
    assign op_onehot = (in_op != 10'd0) && ((in_op & (in_op - 10'd1)) == 10'd0);

    // Requests are only taken in IDLE, and never while reset is held, even
    // though the asynchronous reset already parks the state in IDLE.
    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    // Single-cycle result for every one-hot operation. In the serial build
    // the shift entries only matter for a zero shift amount, where the
    // result is operand A unchanged; nonzero shifts go through SHIFT.
    always_comb begin
        alu_result = '0;
        if (in_op[0]) begin
            alu_result = in_a + in_b;
        end else if (in_op[1]) begin
            alu_result = in_a - in_b;
        end else if (in_op[2]) begin
            alu_result = in_a ^ in_b;
        end else if (in_op[3]) begin
            alu_result = in_a | in_b;
        end else if (in_op[4]) begin
            alu_result = in_a & in_b;
`ifdef ALU_SEQ_FAST_SHIFT_EN
        end else if (in_op[5]) begin
            alu_result = in_a << shamt;
        end else if (in_op[6]) begin
            alu_result = in_a >> shamt;
        end else if (in_op[7]) begin
            alu_result = $signed(in_a) >>> shamt;
`else
        end else if (is_shift) begin
            alu_result = in_a;
`endif
        end else if (in_op[8]) begin
            alu_result = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
        end else if (in_op[9]) begin
            alu_result = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
        end
    end

`ifndef ALU_SEQ_FAST_SHIFT_EN
    // One-bit step of the serial shifter. shift_kind keeps the captured
    // sll/srl/sra bits so later changes on in_op cannot disturb it.
    always_comb begin
        shift_next = shift_q;
        if (shift_kind[0]) begin
            shift_next = {shift_q[WIDTH-2:0], 1'b0};
        end else if (shift_kind[1]) begin
            shift_next = {1'b0, shift_q[WIDTH-1:1]};
        end else if (shift_kind[2]) begin
            shift_next = {shift_q[WIDTH-1], shift_q[WIDTH-1:1]};
        end
    end
`endif

    // Sequencer. IDLE captures a request and either finishes it at once
    // (DONE next cycle) or, for a nonzero serial shift, loads the counter
    // and enters SHIFT. SHIFT shifts once per cycle and leaves on the step
    // that takes the counter from 1 to 0, so a shift by N spends N cycles
    // there. DONE holds the registered result until it is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
`ifndef ALU_SEQ_FAST_SHIFT_EN
            cnt        <= '0;
            shift_q    <= '0;
            shift_kind <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!op_onehot) begin
                            out_result <= '0;
                            out_err    <= 1'b1;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end
`ifndef ALU_SEQ_FAST_SHIFT_EN
                        else if (is_shift && (shamt != '0)) begin
                            shift_q    <= in_a;
                            shift_kind <= in_op[7:5];
                            cnt        <= shamt;
                            state      <= SHIFT;
                        end
`endif
                        else begin
                            out_result <= alu_result;
                            out_err    <= 1'b0;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                SHIFT: begin
`ifndef ALU_SEQ_FAST_SHIFT_EN
                    shift_q <= shift_next;
                    cnt     <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        out_result <= shift_next;
                        out_err    <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq : directed self-checking bench for alu_seq (WIDTH = 32).
// Each vector carries a hand-computed result, error flag and latency.
// Shift latencies follow the build: N+1 serial, 1 with
// ALU_SEQ_FAST_SHIFT_EN defined.
module tb_alu_seq;

    localparam int WIDTH = 32;

    localparam logic [9:0] OP_ADD  = 10'b00_0000_0001;
    localparam logic [9:0] OP_SUB  = 10'b00_0000_0010;
    localparam logic [9:0] OP_XOR  = 10'b00_0000_0100;
    localparam logic [9:0] OP_OR   = 10'b00_0000_1000;
    localparam logic [9:0] OP_AND  = 10'b00_0001_0000;
    localparam logic [9:0] OP_SLL  = 10'b00_0010_0000;
    localparam logic [9:0] OP_SRL  = 10'b00_0100_0000;
    localparam logic [9:0] OP_SRA  = 10'b00_1000_0000;
    localparam logic [9:0] OP_SLT  = 10'b01_0000_0000;
    localparam logic [9:0] OP_SLTU = 10'b10_0000_0000;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [9:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_err;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .busy       (busy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected latency of a shift by n in the current build.
    function automatic int shiftLatency(input int n);
`ifdef ALU_SEQ_FAST_SHIFT_EN
        shiftLatency = 1;
`else
        shiftLatency = (n == 0) ? 1 : n + 1;
`endif
    endfunction

    // Present one request, hold it until accepted, then scramble the inputs
    // so a design that does not register them gives wrong answers. Returns
    // #1 after the accept edge (the accept+1 cycle).
    task automatic applyStimulus(input logic [9:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
        int wait_cycles;
        wait_cycles = 0;
        while (!in_ready && wait_cycles < 100) begin
            @(posedge clk);
            #1;
            wait_cycles++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 10'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
    endtask

    // Issue, measure latency to out_valid, check result and error, consume.
    task automatic runOp(input string tag, input logic [9:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_res, input logic exp_err,
                         input int exp_lat);
        int lat;
        out_ready = 1'b1;
        applyStimulus(op, a, b);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_res"}, 64'(out_result), 64'(exp_res));
        checkOutput({tag, "_err"}, 64'(out_err), 64'(exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vld_count;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        #3;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_result", 64'(out_result), 64'd0);
        checkOutput("rst_out_err", 64'(out_err), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);

        // Release between edges; the very next edge must accept.
        #9;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] arithmetic and logic vectors");
        runOp("sub",  OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1);
        runOp("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        runOp("xor",  OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1);
        runOp("or",   OP_OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1);
        runOp("and",  OP_AND,  32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, 1'b0, 1);
        runOp("slt",  OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
        runOp("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);

        $display("[TB] shift vectors");
        runOp("sra4",  OP_SRA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, shiftLatency(4));
        runOp("srl0",  OP_SRL, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0, shiftLatency(0));
        runOp("sll1",  OP_SLL, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0, shiftLatency(1));
        runOp("srl31", OP_SRL, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, shiftLatency(31));

        $display("[TB] illegal op codes");
        runOp("err_two", 10'b00_0000_0011, 32'h0000_00AA, 32'h0000_0055, 32'h0, 1'b1, 1);
        runOp("err_zero", 10'b00_0000_0000, 32'h0000_00AA, 32'h0000_0055, 32'h0, 1'b1, 1);

        $display("[TB] result held under back-pressure");
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 32'd1, 32'd2);
        checkOutput("hold_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 6; i++) begin
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_result", 64'(out_result), 64'd3);
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'b1;
            in_op    = OP_XOR;
            in_a     = 32'hDEAD_BEEF;
            in_b     = 32'h1234_5678;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        checkOutput("hold_last_result", 64'(out_result), 64'd3);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("consume_in_ready", 64'(in_ready), 64'd1);
        checkOutput("consume_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("no_stray_valid", 64'(out_valid), 64'd0);

        $display("[TB] reset during a long shift");
        applyStimulus(OP_SLL, 32'd1, 32'd31);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd0);
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        #2;
        rst = 1'b0;
        vld_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) vld_count++;
        end
        checkOutput("abort_no_valid", 64'(vld_count), 64'd0);
        runOp("add_after_abort", OP_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
